// File: rtl/regfile_write_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_bank_if
// Description : Write/clear handshake bundle for the register-file write bank.
//               master : drives wr_valid, wr_addr, wr_data, clr_req
//                        and observes wr_ready, clr_done.
//               slave  : the write bank itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_bank_if #(
  parameter int WIDTH = 32
);
  logic             wr_valid;
  logic             wr_ready;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr_req;
  logic             clr_done;

  modport master (
    output wr_valid, wr_addr, wr_data, clr_req,
    input  wr_ready, clr_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_req,
    output wr_ready, clr_done
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_bank.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_bank
// Description : Write side of a 32-entry register file. Requests are staged
//               for one edge, then committed to the array. Entry 0 is
//               hardwired to zero. A clear sweeps entries 1..31, one per edge.
// Ports       : clk, rst_n    - clock, asynchronous active-low reset
//               bus (slave)   - wr_valid/wr_ready/wr_addr/wr_data,
//                               clr_req/clr_done
//               onehot_en     - one-hot of the write committed on last edge
//               wr_count      - committed writes to entries 1..31 (wraps)
//               regs_flat     - all entries, entry i at [WIDTH*i +: WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_bank #(
  parameter int WIDTH = 32
) (
  input  wire                    clk,
  input  wire                    rst_n,
  regfile_write_bank_if.slave    bus,
  output logic [31:0]            onehot_en,
  output logic [15:0]            wr_count,
  output logic [32*WIDTH-1:0]    regs_flat
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic             stg_valid_q, stg_valid_d;
  logic [4:0]       stg_addr_q, stg_addr_d;
  logic [WIDTH-1:0] stg_data_q, stg_data_d;
  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];
  logic [31:0]      onehot_q, onehot_d;
  logic [15:0]      count_q, count_d;
  logic             clr_done_q, clr_done_d;

  logic accept;
  logic commit;

  // Clear wins over a write presented in the same cycle.
  assign bus.wr_ready = (state_q == IDLE) && !bus.clr_req;
  assign accept       = bus.wr_valid && bus.wr_ready;
  // Writes to entry 0 pass through the stage but never commit.
  assign commit       = stg_valid_q && (stg_addr_q != 5'd0);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    clr_done_d  = 1'b0;
    stg_valid_d = accept;
    stg_addr_d  = accept ? bus.wr_addr : stg_addr_q;
    stg_data_d  = accept ? bus.wr_data : stg_data_q;
    onehot_d    = commit ? (32'd1 << stg_addr_q) : 32'd0;
    count_d     = count_q + {15'd0, commit};
    regs_d      = regs_q;

    if (commit) begin
      regs_d[stg_addr_q] = stg_data_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          idx_d   = 5'd1;
        end
      end
      CLEAR: begin
        // Nothing is staged while clearing, so this cannot collide with a commit.
        regs_d[idx_q] = '0;
        idx_d         = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 5'd1;
      stg_valid_q <= 1'b0;
      stg_addr_q  <= 5'd0;
      stg_data_q  <= '0;
      onehot_q    <= 32'd0;
      count_q     <= 16'd0;
      clr_done_q  <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
      onehot_q    <= onehot_d;
      count_q     <= count_d;
      clr_done_q  <= clr_done_d;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.clr_done = clr_done_q;
  assign onehot_en    = onehot_q;
  assign wr_count     = count_q;

  for (genvar g = 0; g < 32; g++) begin : g_flat
    assign regs_flat[WIDTH*g +: WIDTH] = regs_q[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_bank
// Description : Directed self-checking bench for regfile_write_bank. Inputs
//               change on the falling edge; outputs are sampled there too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_bank;

  localparam int C_WIDTH = 32;

  logic                   clk;
  logic                   rst_n;
  logic [31:0]            onehot_en;
  logic [15:0]            wr_count;
  logic [32*C_WIDTH-1:0]  regs_flat;

  int checks;
  int failures;

  regfile_write_bank_if #(.WIDTH(C_WIDTH)) bus ();

  regfile_write_bank #(.WIDTH(C_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .onehot_en (onehot_en),
    .wr_count  (wr_count),
    .regs_flat (regs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [C_WIDTH-1:0] entry(input int i);
    return regs_flat[C_WIDTH*i +: C_WIDTH];
  endfunction

  // Present one write for one cycle, starting and ending on a falling edge.
  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  // Wait (bounded) for the clr_done pulse; returns on the sample showing it.
  task automatic wait_done(input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      if (bus.clr_done) seen = 1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    int low_cnt;
    int done_cnt;
    int done_at;
    int bad;

    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 5'd0;
    bus.wr_data  = 32'd0;
    bus.clr_req  = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_flat_zero", 64'(|regs_flat), 64'd0);
    chk("rst_ready",     64'(bus.wr_ready), 64'd1);
    chk("rst_onehot",    64'(onehot_en), 64'd0);
    chk("rst_count",     64'(wr_count), 64'd0);
    chk("rst_clr_done",  64'(bus.clr_done), 64'd0);

    // Single write, latency of two edges
    wr1(5'd5, 32'hDEADBEEF);
    chk("w5_not_yet",    64'(entry(5)), 64'd0);
    chk("w5_onehot_pre", 64'(onehot_en), 64'd0);
    @(negedge clk);
    chk("w5_data",       64'(entry(5)), 64'hDEADBEEF);
    chk("w5_onehot",     64'(onehot_en), 64'h20);
    chk("w5_count",      64'(wr_count), 64'd1);
    @(negedge clk);
    chk("w5_onehot_clr", 64'(onehot_en), 64'd0);

    // Write to entry 0 is dropped
    wr1(5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("w0_entry",  64'(entry(0)), 64'd0);
    chk("w0_onehot", 64'(onehot_en), 64'd0);
    chk("w0_count",  64'(wr_count), 64'd1);

    // Back-to-back, same address twice then entry 31
    bus.wr_valid = 1'b1;
    bus.wr_addr = 5'd3;  bus.wr_data = 32'h11;
    @(negedge clk);
    bus.wr_addr = 5'd3;  bus.wr_data = 32'h22;
    @(negedge clk);
    chk("b2b_oh1", 64'(onehot_en), 64'h8);
    chk("b2b_e3_first", 64'(entry(3)), 64'h11);
    bus.wr_addr = 5'd31; bus.wr_data = 32'h33;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk("b2b_oh2", 64'(onehot_en), 64'h8);
    @(negedge clk);
    chk("b2b_oh3",   64'(onehot_en), 64'h80000000);
    chk("b2b_e3",    64'(entry(3)), 64'h22);
    chk("b2b_e31",   64'(entry(31)), 64'h33);
    chk("b2b_count", 64'(wr_count), 64'd4);

    // Fill entries 1..31 with their index, no bubbles
    bus.wr_valid = 1'b1;
    for (int i = 1; i < 32; i++) begin
      bus.wr_addr = 5'(i);
      bus.wr_data = 32'(i);
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int i = 1; i < 32; i++) if (entry(i) !== 32'(i)) bad++;
    chk("fill_bad_entries", 64'(bad), 64'd0);
    chk("fill_count", 64'(wr_count), 64'd35);

    // Clear-all sweep
    bus.clr_req = 1'b1;
    #1;
    chk("clr_req_ready", 64'(bus.wr_ready), 64'd0);
    @(negedge clk);
    bus.clr_req = 1'b0;
    low_cnt  = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int k = 0; k < 40; k++) begin
      if (!bus.wr_ready) low_cnt++;
      if (bus.clr_done) begin
        done_cnt++;
        done_at = k;
      end
      @(negedge clk);
    end
    chk("clr_low_cycles", 64'(low_cnt), 64'd31);
    chk("clr_done_count", 64'(done_cnt), 64'd1);
    chk("clr_done_at",    64'(done_at), 64'd31);
    chk("clr_flat_zero",  64'(|regs_flat), 64'd0);
    chk("clr_count",      64'(wr_count), 64'd35);

    // Clear and write in the same cycle with a write to 7 already staged
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd7;
    bus.wr_data  = 32'h77;
    @(negedge clk);
    bus.wr_addr  = 5'd9;
    bus.wr_data  = 32'h99;
    bus.clr_req  = 1'b1;
    #1;
    chk("mix_ready", 64'(bus.wr_ready), 64'd0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.clr_req  = 1'b0;
    chk("mix_e7_commit", 64'(entry(7)), 64'h77);
    chk("mix_onehot",    64'(onehot_en), 64'h80);
    @(negedge clk);
    chk("mix_onehot_clear", 64'(onehot_en), 64'd0);
    wait_done("mix_done_seen");
    chk("mix_e7_zero", 64'(entry(7)), 64'd0);
    chk("mix_e9_zero", 64'(entry(9)), 64'd0);
    chk("mix_count",   64'(wr_count), 64'd36);

    // Async reset with a write staged
    @(negedge clk);
    wr1(5'd12, 32'hAB);
    @(negedge clk);
    chk("pre_rst_e12", 64'(entry(12)), 64'hAB);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd13;
    bus.wr_data  = 32'hCD;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_flat",   64'(|regs_flat), 64'd0);
    chk("arst_onehot", 64'(onehot_en), 64'd0);
    chk("arst_count",  64'(wr_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_e13_discarded", 64'(entry(13)), 64'd0);
    chk("arst_count_after",   64'(wr_count), 64'd0);

    // Async reset mid-clear returns to IDLE immediately
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("midclr_ready_low", 64'(bus.wr_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midclr_ready_rst", 64'(bus.wr_ready), 64'd1);
    chk("midclr_done_rst",  64'(bus.clr_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midclr_ready_after", 64'(bus.wr_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
